gray_decoder: RTL and testbench
===============================

GRAY_DECODER -- requirements
Module: gray_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the Gray/binary code width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth (legal values 2..4).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge triggered.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port g_in, input, WIDTH bits: Gray-coded position that is asynchronous to clk.
REQ-006 SHALL have port en, input, 1 bit: tracking enable.
REQ-007 SHALL have port clr, input, 1 bit: synchronous clear of err and step_cnt, plus a baseline reload.
REQ-008 SHALL have port bin_out, output, WIDTH bits: registered binary decode of the synchronized g_in.
REQ-009 SHALL have port chg, output, 1 bit: single-cycle pulse on each valid one-step change.
REQ-010 SHALL have port up, output, 1 bit: direction of the last valid step (1 = increment).
REQ-011 SHALL have port err, output, 1 bit: sticky illegal-transition flag.
REQ-012 SHALL have port step_cnt, output, 8 bits: two's-complement net step count.

Function
REQ-013 SHALL pass g_in through SYNC_STAGES flops; the synchronizer runs every cycle regardless of en.
REQ-014 SHALL decode the last synchronizer stage Gray->binary (b[MSB]=g[MSB]; b[i]=b[i+1]^g[i]) and register the result into bin_out.
REQ-015 SHALL have latency as follows: a g_in held stable appears on bin_out SYNC_STAGES+1 rising edges later.
REQ-016 SHALL implement FSM states INIT, TRACK and FAULT; reset state is INIT.
REQ-017 SHALL, in INIT, take the new decoded value as baseline, not pulse chg, and go to TRACK on the next edge if en=1.
REQ-018 SHALL, in TRACK, compute d = (new - baseline) mod 2^WIDTH each cycle:
  - d=0: no action.
  - d=1: pulse chg, set up=1, step_cnt+1.
  - d=2^WIDTH-1: pulse chg, set up=0, step_cnt-1.
  - any other d: set err=1, go to FAULT, leave chg=0 and step_cnt unchanged.
  - in every case, the baseline becomes the new value.
REQ-019 SHALL treat wrap-around as a legal single step: 15->0 is up, 0->15 is down (for WIDTH=4).
REQ-020 SHALL, in FAULT, keep bin_out following the input, suppress chg and counting, and hold err=1 until clr.
REQ-021 SHALL, on clr=1 in any state: err<=0, step_cnt<=0, chg<=0, next state INIT; clr wins over a simultaneous step.
REQ-022 SHALL, on en=0: next state INIT, chg<=0, bin_out keeps updating, step_cnt holds, err holds.
REQ-023 SHALL let step_cnt wrap modulo 256 (127+1 -> -128); there is no saturation.
REQ-024 SHALL drive chg high for exactly one cycle per valid step and never for two consecutive cycles unless the decoded value changes on both.

Reset
REQ-025 SHALL, while rst_n=0, immediately and asynchronously drive all synchronizer flops to 0, bin_out to 0, chg to 0, up to 0, err to 0, step_cnt to 0, and the state to INIT.
REQ-026 SHALL release reset synchronously: the first active edge after rst_n rises evaluates in INIT; a reset asserted mid-step discards that step.

Structure
REQ-027 SHALL keep the FSM state encodings (INIT=2'b00, TRACK=2'b01, FAULT=2'b10) and the default WIDTH/SYNC_STAGES in a shared package gray_pkg, reused by the existing binary-to-Gray encoder's benches.
REQ-028 SHALL instantiate one combinational sub-module gray2bin (WIDTH-parameterized) for the decode; all other logic stays in gray_decoder.
REQ-029 SHALL be fully synthesizable with no latches; synchronizer flops marked for the CDC tool.

Verification (WIDTH=4, SYNC_STAGES=2)
REQ-030 SHALL cover reset then steady input: reset, en=1, g_in=0000 held -> bin_out=0 after 3 edges, chg never high, err=0, step_cnt=0.
REQ-031 SHALL cover an up sequence: g_in 0000,0001,0011,0010, each held 4 cycles -> bin_out 0,1,2,3; three chg pulses each 3 edges after the input change; up=1; step_cnt=3.
REQ-032 SHALL cover wrap-around: g_in 1000 (bin 15) then 0000 -> chg, up=1, bin_out=0; then back to 1000 -> chg, up=0, bin_out=15, step_cnt decrements by 1.
REQ-033 SHALL cover an illegal transition: g_in 0000 then 0011 (bin 2) -> err=1, chg=0, step_cnt unchanged, bin_out=2; further legal steps do not count; clr pulse -> err=0, step_cnt=0, tracking resumes.
REQ-034 SHALL cover clr coincident with a step: clr=1 in the same cycle as a 0->1 step -> chg=0, step_cnt=0, baseline=1, and the next step 1->2 counts as +1.
REQ-035 SHALL cover reset mid-run: rst_n dropped between clock edges with step_cnt=5 -> all outputs 0 before the next edge; after release, the first held value is loaded without chg.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code defaults and decoder FSM state encodings
package gray_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_SYNC_STAGES = 2;
  typedef enum logic [1:0] {INIT = 2'b00, TRACK = 2'b01, FAULT = 2'b10} state_t;
endpackage

// File: rtl/gray_decoder_if.sv
// gray_decoder_if: Gray decoder signal bundle
//   g_in/en/clr    : position input and controls (master -> slave)
//   bin_out/chg/up : decoded value, step pulse, step direction (slave -> master)
//   err/step_cnt   : sticky illegal-step flag, signed net step count (slave -> master)
interface gray_decoder_if import gray_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic [WIDTH-1:0] g_in;
  logic en;
  logic clr;
  logic [WIDTH-1:0] bin_out;
  logic chg;
  logic up;
  logic err;
  logic [7:0] step_cnt;
  modport master(output g_in, en, clr, input bin_out, chg, up, err, step_cnt);
  modport slave(input g_in, en, clr, output bin_out, chg, up, err, step_cnt);
endinterface

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary decode
//   g : Gray code in
//   b : binary out, each bit is the XOR of all Gray bits at or above it
module gray2bin #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign b[i] = ^g[WIDTH-1:i];
  end
endmodule

// File: rtl/gray_decoder.sv
// gray_decoder: synchronizes an async Gray position, decodes it and tracks single steps
//   clk, rst_n : clock, asynchronous active-low reset
//   io         : gray_decoder_if slave (g_in, en, clr in; bin_out, chg, up, err, step_cnt out)
module gray_decoder import gray_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input logic clk,
  input logic rst_n,
  gray_decoder_if.slave io
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] dec, d, bin_q;
  logic chg_q, up_q, err_q, chg_d, up_d, err_d;
  logic [7:0] cnt_q, cnt_d;
  state_t state_q, state_d;
  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (.g(sync_q[SYNC_STAGES-1]), .b(dec));
  // bin_out reloads every cycle, so it doubles as the tracking baseline
  assign d = dec - bin_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      bin_q <= '0;
      chg_q <= 1'b0;
      up_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
      state_q <= INIT;
    end else begin
      sync_q[0] <= io.g_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      bin_q <= dec;
      chg_q <= chg_d;
      up_q <= up_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
    end
  end
  always_comb begin
    state_d = state_q;
    chg_d = 1'b0;
    up_d = up_q;
    err_d = err_q;
    cnt_d = cnt_q;
    if (io.clr) begin
      state_d = INIT;
      err_d = 1'b0;
      cnt_d = '0;
    end else if (!io.en) begin
      state_d = INIT;
    end else begin
      case (state_q)
        INIT: state_d = TRACK;
        TRACK:
          if (d == WIDTH'(1)) begin
            chg_d = 1'b1;
            up_d = 1'b1;
            cnt_d = cnt_q + 8'd1;
          end else if (d == '1) begin
            chg_d = 1'b1;
            up_d = 1'b0;
            cnt_d = cnt_q - 8'd1;
          end else if (d != '0) begin
            err_d = 1'b1;
            state_d = FAULT;
          end
        FAULT: state_d = FAULT;
        default: state_d = INIT;
      endcase
    end
  end
  assign io.bin_out = bin_q;
  assign io.chg = chg_q;
  assign io.up = up_q;
  assign io.err = err_q;
  assign io.step_cnt = cnt_q;
endmodule

// File: tb/tb_gray_decoder.sv
// tb_gray_decoder: directed self-checking bench for gray_decoder (WIDTH=4, SYNC_STAGES=2)
module tb_gray_decoder;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_err = 0;
  gray_decoder_if #(.WIDTH(4)) io ();
  gray_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .io(io.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  function automatic logic [3:0] to_gray(input logic [3:0] v);
    return v ^ (v >> 1);
  endfunction
  task automatic apply(input logic [3:0] g, input logic [3:0] eb, input logic ec,
                       input logic eu, input logic [7:0] ecnt, input logic ee);
    io.g_in = g;
    tick();
    tick();
    check("chg_early", io.chg, 0);
    tick();
    check("bin_out", io.bin_out, eb);
    check("chg", io.chg, ec);
    check("up", io.up, eu);
    check("step_cnt", io.step_cnt, ecnt);
    check("err", io.err, ee);
    tick();
    check("chg_once", io.chg, 0);
  endtask
  task automatic clr_pulse();
    io.clr = 1'b1;
    tick();
    io.clr = 1'b0;
    check("clr_err", io.err, 0);
    check("clr_cnt", io.step_cnt, 0);
    check("clr_chg", io.chg, 0);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_bin"}, io.bin_out, 0);
    check({tag, "_chg"}, io.chg, 0);
    check({tag, "_up"}, io.up, 0);
    check({tag, "_err"}, io.err, 0);
    check({tag, "_cnt"}, io.step_cnt, 0);
  endtask
  initial begin
    rst_n = 1'b0;
    io.g_in = 4'b0000;
    io.en = 1'b0;
    io.clr = 1'b0;
    tick();
    check_zero("rst");
    rst_n = 1'b1;
    io.en = 1'b1;
    // steady input
    apply(4'b0000, 4'd0, 0, 0, 8'h00, 0);
    // up sequence
    apply(4'b0001, 4'd1, 1, 1, 8'h01, 0);
    apply(4'b0011, 4'd2, 1, 1, 8'h02, 0);
    apply(4'b0010, 4'd3, 1, 1, 8'h03, 0);
    // walk back down to 0
    apply(4'b0011, 4'd2, 1, 0, 8'h02, 0);
    apply(4'b0001, 4'd1, 1, 0, 8'h01, 0);
    apply(4'b0000, 4'd0, 1, 0, 8'h00, 0);
    // wrap-around both directions
    apply(4'b1000, 4'd15, 1, 0, 8'hff, 0);
    apply(4'b0000, 4'd0, 1, 1, 8'h00, 0);
    apply(4'b1000, 4'd15, 1, 0, 8'hff, 0);
    apply(4'b0000, 4'd0, 1, 1, 8'h00, 0);
    // illegal jump 0 -> 2, then a legal step in FAULT does not count
    apply(4'b0011, 4'd2, 0, 1, 8'h00, 1);
    apply(4'b0010, 4'd3, 0, 1, 8'h00, 1);
    clr_pulse();
    apply(4'b0011, 4'd2, 1, 0, 8'hff, 0);
    apply(4'b0001, 4'd1, 1, 0, 8'hfe, 0);
    apply(4'b0000, 4'd0, 1, 0, 8'hfd, 0);
    // clr coincident with a 0 -> 1 step
    io.g_in = 4'b0001;
    tick();
    tick();
    io.clr = 1'b1;
    tick();
    io.clr = 1'b0;
    check("coinc_chg", io.chg, 0);
    check("coinc_cnt", io.step_cnt, 0);
    check("coinc_bin", io.bin_out, 1);
    apply(4'b0011, 4'd2, 1, 1, 8'h01, 0);
    // step_cnt wraps 127 -> -128
    clr_pulse();
    for (int k = 1; k <= 128; k++) begin
      logic [3:0] v;
      v = 4'(2 + k);
      apply(to_gray(v), v, 1, 1, 8'(k), 0);
    end
    // reset mid-run with step_cnt = 5
    clr_pulse();
    for (int k = 1; k <= 5; k++) begin
      logic [3:0] v;
      v = 4'(2 + k);
      apply(to_gray(v), v, 1, 1, 8'(k), 0);
    end
    check("pre_rst_cnt", io.step_cnt, 5);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    io.en = 1'b0;
    io.g_in = 4'b0110;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("load_bin", io.bin_out, 4);
    check("load_chg", io.chg, 0);
    io.en = 1'b1;
    tick();
    tick();
    tick();
    check("resume_bin", io.bin_out, 4);
    check("resume_chg", io.chg, 0);
    check("resume_err", io.err, 0);
    check("resume_cnt", io.step_cnt, 0);
    check("resume_up", io.up, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
